cmul_seq: RTL

- Sequencer that computes one complex fixed-point product by time-sharing a single `fixmul` instance (IN_BITS = OUT_BITS = WIDTH) over four cycles.
- Sits between the gate-application unit, which supplies a state amplitude and a gate coefficient, and the amplitude write-back path.
- Uses valid/ready handshakes on both sides.
- Replaces four parallel real multipliers with one, trading throughput for area.

---
 rtl/cmul_seq.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/cmul_seq.sv
// Sequential complex multiplier: one shared fixmul over four cycles computes
// a*b (or a*conj(b)) with saturated WIDTH-bit fixed-point results.

module fixmul #(
  parameter int IN_BITS  = 19,
  parameter int OUT_BITS = 19
) (
  input  logic [IN_BITS-1:0]  a,
  input  logic [IN_BITS-1:0]  b,
  output logic [OUT_BITS-1:0] p
);
  localparam int MW   = IN_BITS - 1;
  localparam int FRAC = IN_BITS - 2;

  logic [MW-1:0]       mag_a, mag_b;
  logic [2*MW-1:0]     prod;
  logic [OUT_BITS-2:0] mag_p;
  logic                neg;

  // Sign-magnitude multiply so truncation is toward zero and zero is never negative.
  always_comb begin
    mag_a = a[IN_BITS-1] ? MW'(-a) : a[MW-1:0];
    mag_b = b[IN_BITS-1] ? MW'(-b) : b[MW-1:0];
    prod  = {{MW{1'b0}}, mag_a} * {{MW{1'b0}}, mag_b};
    mag_p = (OUT_BITS-1)'(prod >> FRAC);
    neg   = a[IN_BITS-1] ^ b[IN_BITS-1];
    p     = (neg && (mag_p != '0)) ? -{1'b0, mag_p} : {1'b0, mag_p};
  end
endmodule

module cmul_seq #(
  parameter int WIDTH = 19
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a_re,
  input  logic [WIDTH-1:0] a_im,
  input  logic [WIDTH-1:0] b_re,
  input  logic [WIDTH-1:0] b_im,
  input  logic             conj_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_re,
  output logic [WIDTH-1:0] out_im,
  output logic             busy,
  output logic [2:0]       dbg_state
);
  typedef enum logic [2:0] {IDLE, MUL0, MUL1, MUL2, MUL3, DONE} state_t;

  localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH:0]   SAT_MAX  = {2'b00, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH:0]   SAT_MIN  = {2'b11, {(WIDTH-2){1'b0}}, 1'b1};

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_re_q, a_re_d, a_im_q, a_im_d;
  logic [WIDTH-1:0] b_re_q, b_re_d, b_im_q, b_im_d;
  logic             conj_q, conj_d;
  logic [WIDTH-1:0] p_hold_q, p_hold_d;
  logic [WIDTH-1:0] out_re_q, out_re_d, out_im_q, out_im_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] mul_x, mul_y, mul_p;
  logic [WIDTH:0]   p_ext, m_ext, sum_add, sum_sub;

  function automatic logic [WIDTH-1:0] clamp_op(input logic [WIDTH-1:0] v);
    return (v == MOST_NEG) ? MOST_NEG + 1'b1 : v;
  endfunction

  function automatic logic [WIDTH-1:0] sat(input logic [WIDTH:0] s);
    if ($signed(s) > $signed(SAT_MAX))      return WIDTH'(SAT_MAX);
    else if ($signed(s) < $signed(SAT_MIN)) return WIDTH'(SAT_MIN);
    else                                    return WIDTH'(s);
  endfunction

  // Operand mux depends on the state register alone.
  always_comb begin
    mul_x = '0;
    mul_y = '0;
    case (state_q)
      MUL0:    begin mul_x = a_re_q; mul_y = b_re_q; end
      MUL1:    begin mul_x = a_im_q; mul_y = b_im_q; end
      MUL2:    begin mul_x = a_im_q; mul_y = b_re_q; end
      MUL3:    begin mul_x = a_re_q; mul_y = b_im_q; end
      default: ;
    endcase
  end

  fixmul #(.IN_BITS(WIDTH), .OUT_BITS(WIDTH)) u_fixmul (
    .a(mul_x),
    .b(mul_y),
    .p(mul_p)
  );

  always_comb begin
    p_ext   = {p_hold_q[WIDTH-1], p_hold_q};
    m_ext   = {mul_p[WIDTH-1], mul_p};
    sum_add = p_ext + m_ext;
    sum_sub = p_ext - m_ext;
  end

  always_comb begin
    state_d     = state_q;
    a_re_d      = a_re_q;
    a_im_d      = a_im_q;
    b_re_d      = b_re_q;
    b_im_d      = b_im_q;
    conj_d      = conj_q;
    p_hold_d    = p_hold_q;
    out_re_d    = out_re_q;
    out_im_d    = out_im_q;
    out_valid_d = 1'b0;
    case (state_q)
      IDLE: if (in_valid) begin
        a_re_d  = clamp_op(a_re);
        a_im_d  = clamp_op(a_im);
        b_re_d  = clamp_op(b_re);
        b_im_d  = clamp_op(b_im);
        conj_d  = conj_b;
        state_d = MUL0;
      end
      MUL0: begin
        p_hold_d = mul_p;
        state_d  = MUL1;
      end
      MUL1: begin
        out_re_d = conj_q ? sat(sum_add) : sat(sum_sub);
        state_d  = MUL2;
      end
      MUL2: begin
        p_hold_d = mul_p;
        state_d  = MUL3;
      end
      MUL3: begin
        out_im_d    = conj_q ? sat(sum_sub) : sat(sum_add);
        out_valid_d = 1'b1;
        state_d     = DONE;
      end
      DONE: begin
        out_valid_d = !out_ready;
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      a_re_q      <= '0;
      a_im_q      <= '0;
      b_re_q      <= '0;
      b_im_q      <= '0;
      conj_q      <= 1'b0;
      p_hold_q    <= '0;
      out_re_q    <= '0;
      out_im_q    <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_re_q      <= a_re_d;
      a_im_q      <= a_im_d;
      b_re_q      <= b_re_d;
      b_im_q      <= b_im_d;
      conj_q      <= conj_d;
      p_hold_q    <= p_hold_d;
      out_re_q    <= out_re_d;
      out_im_q    <= out_im_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign out_valid = out_valid_q;
  assign out_re    = out_re_q;
  assign out_im    = out_im_q;
  assign dbg_state = state_q;
endmodule
